regfile_mp_sb: RTL and testbench



---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_mp_sb_if.sv | 32 +++
 rtl/regfile_clr_fsm.sv | 70 +++++++
 rtl/regfile_mp_sb.sv | 102 ++++++++++
 tb/tb_regfile_mp_sb.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
package regfile_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned DEF_NUM_RD = 2;

    // Entry that reads as zero when the hardwired-zero option is enabled
    localparam int unsigned ZERO_ADDR  = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Read / write / reserve / clear bundle between the issue logic and the register file.
interface regfile_mp_sb_if
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned NUM_RD = DEF_NUM_RD
) ();

    logic [NUM_RD*ADDR_W-1:0] rdAddr;
    logic [NUM_RD*DATA_W-1:0] rdData;
    logic [NUM_RD-1:0]        rdPending;
    logic                     wrEn;
    logic [ADDR_W-1:0]        wrAddr;
    logic [DATA_W-1:0]        wrData;
    logic                     rsvEn;
    logic [ADDR_W-1:0]        rsvAddr;
    logic                     clrReq;
    logic                     clrBusy;
    logic                     clrDone;

    modport master (
        output rdAddr, wrEn, wrAddr, wrData, rsvEn, rsvAddr, clrReq,
        input  rdData, rdPending, clrBusy, clrDone
    );

    modport slave (
        input  rdAddr, wrEn, wrAddr, wrData, rsvEn, rsvAddr, clrReq,
        output rdData, rdPending, clrBusy, clrDone
    );

endinterface

// File: rtl/regfile_clr_fsm.sv
// Clear sequencer: walks every entry once, one per cycle, then pulses done.
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr_req,
    output logic              o_clr_busy,
    output logic              o_clr_done,
    output logic              o_clr_en,
    output logic [ADDR_W-1:0] o_clr_idx
);

    localparam int unsigned       DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    clr_state_t        r_state;
    clr_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx_nxt;

    // State and sweep index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next state: terminal test is an explicit compare against the last index
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        unique case (r_state)
            IDLE: begin
                if (i_clr_req) begin
                    w_state_nxt = SWEEP;
                    w_idx_nxt   = '0;
                end
            end
            SWEEP: begin
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = DONE;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        o_clr_busy = (r_state == SWEEP);
        o_clr_done = (r_state == DONE);
        o_clr_en   = (r_state == SWEEP);
        o_clr_idx  = r_idx;
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with pending scoreboard and sequenced clear.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned NUM_RD   = DEF_NUM_RD,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    regfile_mp_sb_if.slave bus
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0]        r_mem [DEPTH];
    logic [DEPTH-1:0]         r_pend;

    logic                     w_clr_en;
    logic [ADDR_W-1:0]        w_clr_idx;
    logic                     w_clr_busy;
    logic                     w_clr_done;
    logic                     w_wr_ok;
    logic                     w_rsv_ok;
    logic [NUM_RD*DATA_W-1:0] w_rd_data;
    logic [NUM_RD-1:0]        w_rd_pend;

    regfile_clr_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clr_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr_req  (bus.clrReq),
        .o_clr_busy (w_clr_busy),
        .o_clr_done (w_clr_done),
        .o_clr_en   (w_clr_en),
        .o_clr_idx  (w_clr_idx)
    );

    // Writes and reservations are dropped during a sweep and never touch the zero entry
    assign w_wr_ok  = bus.wrEn && !w_clr_en &&
                      !(ZERO_REG && (bus.wrAddr == ADDR_W'(ZERO_ADDR)));
    assign w_rsv_ok = bus.rsvEn && !w_clr_en &&
                      !(ZERO_REG && (bus.rsvAddr == ADDR_W'(ZERO_ADDR)));

    // Storage and scoreboard; a same-cycle reserve overrides the write's pending clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_pend <= '0;
        end else if (w_clr_en) begin
            r_mem[w_clr_idx]  <= '0;
            r_pend[w_clr_idx] <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_mem[bus.wrAddr]  <= bus.wrData;
                r_pend[bus.wrAddr] <= 1'b0;
            end
            if (w_rsv_ok) begin
                r_pend[bus.rsvAddr] <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic              w_hit_zero;
        logic              w_hit_byp;
        logic [DATA_W-1:0] w_data;
        logic              w_pend;

        assign w_addr     = bus.rdAddr[g*ADDR_W +: ADDR_W];
        assign w_hit_zero = ZERO_REG && (w_addr == ADDR_W'(ZERO_ADDR));
        assign w_hit_byp  = BYPASS && w_wr_ok && (bus.wrAddr == w_addr);

        // Read mux: zero entry beats bypass, bypass beats storage
        always_comb begin
            w_data = r_mem[w_addr];
            w_pend = r_pend[w_addr];
            if (w_hit_zero) begin
                w_data = '0;
                w_pend = 1'b0;
            end else if (w_hit_byp) begin
                w_data = bus.wrData;
                w_pend = 1'b0;
            end
        end

        assign w_rd_data[g*DATA_W +: DATA_W] = w_data;
        assign w_rd_pend[g]                  = w_pend;
    end

    assign bus.rdData    = w_rd_data;
    assign bus.rdPending = w_rd_pend;
    assign bus.clrBusy   = w_clr_busy;
    assign bus.clrDone   = w_clr_done;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: bypassing and non-bypassing instances share one stimulus.
module tb_regfile_mp_sb;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    regfile_mp_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();
    regfile_mp_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus_nb ();

    assign bus_nb.rdAddr  = bus.rdAddr;
    assign bus_nb.wrEn    = bus.wrEn;
    assign bus_nb.wrAddr  = bus.wrAddr;
    assign bus_nb.wrData  = bus.wrData;
    assign bus_nb.rsvEn   = bus.rsvEn;
    assign bus_nb.rsvAddr = bus.rsvAddr;
    assign bus_nb.clrReq  = bus.clrReq;

    regfile_mp_sb #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1'b1), .BYPASS(1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    regfile_mp_sb #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1'b1), .BYPASS(1'b0)
    ) dut_nb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_nb)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: storage, pending set, and a clear "age" (cycles since sweep accepted)
    logic [DW-1:0]    m_mem [DEPTH];
    logic [DEPTH-1:0] m_pend;
    int               m_age = -1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
            m_pend <= '0;
            m_age  <= -1;
        end else if (m_age >= 0 && m_age < DEPTH) begin
            m_mem[m_age]  <= '0;
            m_pend[m_age] <= 1'b0;
            m_age         <= m_age + 1;
        end else begin
            if (m_age == DEPTH) m_age <= -1;
            else if (bus.clrReq) m_age <= 0;
            if (bus.wrEn && bus.wrAddr != 0) begin
                m_mem[bus.wrAddr]  <= bus.wrData;
                m_pend[bus.wrAddr] <= 1'b0;
            end
            if (bus.rsvEn && bus.rsvAddr != 0) m_pend[bus.rsvAddr] <= 1'b1;
        end
    end

    // Per-cycle comparison of every output of both instances against the model
    always @(negedge clk) begin : cmp
        logic          busy;
        logic [AW-1:0] a;
        logic [DW-1:0] ed;
        logic          ep;
        busy = (m_age >= 0) && (m_age < DEPTH);
        for (int p = 0; p < NR; p++) begin
            a  = bus.rdAddr[p*AW +: AW];
            ed = m_mem[a];
            ep = m_pend[a];
            if (a == 0) begin
                ed = '0;
                ep = 1'b0;
            end
            check("nb_rd_data", bus_nb.rdData[p*DW +: DW], ed);
            check("nb_rd_pend", 32'(bus_nb.rdPending[p]), 32'(ep));
            if (a != 0 && !busy && bus.wrEn && bus.wrAddr == a) begin
                ed = bus.wrData;
                ep = 1'b0;
            end
            check("rd_data", bus.rdData[p*DW +: DW], ed);
            check("rd_pend", 32'(bus.rdPending[p]), 32'(ep));
        end
        check("clr_busy", 32'(bus.clrBusy), 32'(busy));
        check("clr_done", 32'(bus.clrDone), 32'(m_age == DEPTH));
        check("nb_clr_busy", 32'(bus_nb.clrBusy), 32'(busy));
        check("nb_clr_done", 32'(bus_nb.clrDone), 32'(m_age == DEPTH));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.wrEn   = 1'b0;
        bus.rsvEn  = 1'b0;
        bus.clrReq = 1'b0;
    endtask

    function automatic logic [NR*AW-1:0] rd_pair(input int a1, input int a0);
        return {AW'(a1), AW'(a0)};
    endfunction

    int busy_cnt;
    int done_cnt;
    int seen;

    initial begin
        bus.rdAddr  = '0;
        bus.wrAddr  = '0;
        bus.wrData  = '0;
        bus.rsvAddr = '0;
        quiet();
        rst_n = 1'b0;
        #12;
        check("reset_busy", 32'(bus.clrBusy), 32'd0);
        check("reset_rd0", bus.rdData[DW-1:0], 32'd0);
        rst_n = 1'b1;

        // Plain write then read
        bus.wrEn = 1'b1; bus.wrAddr = 5'd5; bus.wrData = 32'hDEADBEEF;
        step();
        quiet();
        bus.rdAddr = rd_pair(0, 5);
        #1;
        check("wr5_data", bus.rdData[DW-1:0], 32'hDEADBEEF);
        check("wr5_pend", 32'(bus.rdPending[0]), 32'd0);

        // Bypass vs. no bypass on port 1
        bus.rdAddr = rd_pair(7, 5);
        bus.wrEn = 1'b1; bus.wrAddr = 5'd7; bus.wrData = 32'h12345678;
        #1;
        check("byp_same_cycle", bus.rdData[DW +: DW], 32'h12345678);
        check("nobyp_same_cycle", bus_nb.rdData[DW +: DW], 32'd0);
        step();
        quiet();
        #1;
        check("nobyp_next_cycle", bus_nb.rdData[DW +: DW], 32'h12345678);

        // Zero entry ignores writes and reservations
        bus.rdAddr = rd_pair(0, 0);
        bus.wrEn = 1'b1; bus.wrAddr = 5'd0; bus.wrData = 32'hFFFFFFFF;
        bus.rsvEn = 1'b1; bus.rsvAddr = 5'd0;
        #1;
        check("zero_byp_data", bus.rdData[DW +: DW], 32'd0);
        step();
        quiet();
        #1;
        check("zero_data", bus.rdData[DW-1:0], 32'd0);
        check("zero_pend", 32'(bus.rdPending), 32'd0);

        // Scoreboard on entry 9
        bus.rdAddr = rd_pair(5, 9);
        bus.rsvEn = 1'b1; bus.rsvAddr = 5'd9;
        step();
        quiet();
        #1;
        check("rsv9_pend", 32'(bus.rdPending[0]), 32'd1);
        bus.wrEn = 1'b1; bus.wrAddr = 5'd9; bus.wrData = 32'hA5;
        #1;
        check("wr9_byp_pend", 32'(bus.rdPending[0]), 32'd0);
        check("wr9_nb_pend", 32'(bus_nb.rdPending[0]), 32'd1);
        step();
        quiet();
        #1;
        check("wr9_data", bus.rdData[DW-1:0], 32'hA5);
        check("wr9_pend", 32'(bus_nb.rdPending[0]), 32'd0);
        bus.wrEn = 1'b1; bus.wrAddr = 5'd9; bus.wrData = 32'hA5A5;
        bus.rsvEn = 1'b1; bus.rsvAddr = 5'd9;
        step();
        quiet();
        #1;
        check("wrrsv9_data", bus.rdData[DW-1:0], 32'hA5A5);
        check("wrrsv9_pend", 32'(bus.rdPending[0]), 32'd1);
        bus.rsvEn = 1'b1; bus.rsvAddr = 5'd9;
        step();
        quiet();
        #1;
        check("rerSV9_pend", 32'(bus.rdPending[0]), 32'd1);

        // Preload and sweep
        for (int i = 1; i < DEPTH; i++) begin
            bus.wrEn = 1'b1; bus.wrAddr = AW'(i); bus.wrData = 32'h1000_0000 + i;
            step();
        end
        quiet();
        bus.rsvEn = 1'b1; bus.rsvAddr = 5'd3;
        step();
        quiet();
        bus.clrReq = 1'b1;
        step();
        quiet();
        bus.rdAddr = rd_pair(3, 2);
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.clrBusy) busy_cnt++;
            if (bus.clrDone) done_cnt++;
            bus.wrEn = (c == 5); bus.wrAddr = 5'd2; bus.wrData = 32'hBAD;
            bus.rsvEn = (c == 5); bus.rsvAddr = 5'd3;
            bus.clrReq = (c == 8);
            step();
        end
        quiet();
        check("sweep_busy_cycles", 32'(busy_cnt), 32'd32);
        check("sweep_done_pulses", 32'(done_cnt), 32'd1);
        for (int a = 0; a < DEPTH; a++) begin
            bus.rdAddr = rd_pair(DEPTH - 1 - a, a);
            #1;
            check("swept_zero", bus.rdData[DW-1:0], 32'd0);
            step();
        end

        // Reset in the middle of a sweep
        for (int i = 20; i < 23; i++) begin
            bus.wrEn = 1'b1; bus.wrAddr = AW'(i); bus.wrData = 32'h2000_0000 + i;
            step();
        end
        quiet();
        bus.rdAddr = rd_pair(21, 20);
        bus.clrReq = 1'b1;
        step();
        quiet();
        repeat (10) step();
        check("midsweep_busy", 32'(bus.clrBusy), 32'd1);
        check("midsweep_rd20", bus.rdData[DW-1:0], 32'h2000_0014);
        rst_n = 1'b0;
        #1;
        check("async_busy_drop", 32'(bus.clrBusy), 32'd0);
        check("async_rd20", bus.rdData[DW-1:0], 32'd0);
        check("async_rd21", bus.rdData[DW +: DW], 32'd0);
        #1;
        rst_n = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.clrDone) done_cnt++;
            step();
        end
        check("no_done_after_reset", 32'(done_cnt), 32'd0);

        // Restart sweep: index must begin at 0 again
        bus.wrEn = 1'b1; bus.wrAddr = 5'd1; bus.wrData = 32'h11;
        step();
        bus.wrEn = 1'b1; bus.wrAddr = 5'd30; bus.wrData = 32'h30;
        step();
        quiet();
        bus.clrReq = 1'b1;
        step();
        quiet();
        bus.rdAddr = rd_pair(30, 1);
        #1;
        check("restart_busy", 32'(bus.clrBusy), 32'd1);
        check("restart_rd1_before", bus.rdData[DW-1:0], 32'h11);
        step();
        step();
        check("restart_rd1_cleared", bus.rdData[DW-1:0], 32'd0);
        check("restart_rd30_kept", bus.rdData[DW +: DW], 32'h30);
        seen = 0;
        for (int c = 0; c < 40 && seen == 0; c++) begin
            if (bus.clrDone) seen = 1;
            else step();
        end
        check("restart_done_seen", 32'(seen), 32'd1);
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
